radix2_div: RTL and testbench

Sequential signed integer divider, the inverse of the radix-4 multiplier, using the same nd/valid operand interface.
- Produces quotient and remainder of a/b with restoring division, one quotient bit per clock, on operand magnitudes.
- Signs are restored at the end.
- Sits beside the multiplier in the arithmetic library; callers share one nd/valid handshake style.

---
 rtl/radix2_div.sv | 214 +++++++++++++++++++++
 tb/tb_radix2_div.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix2_div.sv
// ---------------------------------------------------------------------------
// radix2_div
//
// Sequential signed integer divider.  Companion to the radix-4 multiplier in
// the arithmetic library and uses the same nd/valid handshake.  The divide
// runs restoring division on the operand magnitudes, one quotient bit per
// clock, and re-applies the signs when the result is registered.
//
// Quotient truncates toward zero and the remainder takes the sign of the
// dividend, so a == q*b + r whenever b != 0.  Dividing by zero returns
// q = -1, r = a and raises div_by_zero alongside valid.
//
// Parameters:
//   WIDTH          operand/result width in bits, two's complement (4..64)
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   nd             new data strobe; a/b taken when nd=1 and busy=0
//   a              signed dividend
//   b              signed divisor
//   q              signed quotient, held until the next result
//   r              signed remainder, held until the next result
//   valid          one-cycle pulse marking q/r/div_by_zero as fresh
//   busy           high while an operation is in flight
//   div_by_zero    set with valid when the divisor was zero
//
// Build option:
//   RADIX2_DIV_EARLY_OUT_EN  when defined, operations with b == 0 or
//                            |a| < |b| bypass the iterative stage and report
//                            one edge after nd.  Otherwise every operation
//                            takes WIDTH+1 edges.
// ---------------------------------------------------------------------------
module radix2_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             nd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             valid,
    output logic             busy,
    output logic             div_by_zero
);

    // Counter just wide enough to hold WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Iteration datapath.  r_quo starts out holding |a|; each step shifts
    // a dividend bit out of its top into the partial remainder and a
    // quotient bit into its bottom, so after WIDTH steps it holds |q|.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_signQ;
    logic             r_signR;
    logic             r_zero;

    // Registered outputs.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_valid;
    logic             r_dbz;

    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic             w_bZero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_qOut;
    logic [WIDTH-1:0] w_rOut;

    // Magnitudes as WIDTH-bit unsigned values.  The most negative operand
    // negates to itself, which read as unsigned is exactly its magnitude.
    assign w_absA  = a[WIDTH-1] ? -a : a;
    assign w_absB  = b[WIDTH-1] ? -b : b;
    assign w_bZero = (b == '0);

    // Trial subtraction one bit wider than the operands: the shifted
    // remainder can reach 2^WIDTH-1, so the extra bit is the borrow that
    // says whether the divisor fit.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_fits  = ~w_diff[WIDTH];

    // Final sign restoration.  A zero divisor forces the all-ones quotient;
    // the remainder path already reproduces a because the magnitude of a
    // is what is left over when nothing is ever subtracted.
    assign w_qOut = r_zero  ? '1 : (r_signQ ? -r_quo : r_quo);
    assign w_rOut = r_signR ? -r_rem : r_rem;

`ifdef RADIX2_DIV_EARLY_OUT_EN
    // Results that need no iteration: quotient 0 with remainder |a|, or the
    // fixed divide-by-zero answer.
    logic w_early;
    assign w_early = w_bZero | (w_absA < w_absB);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.  nd is only looked at in IDLE, so a strobe that
    // arrives while busy is dropped without disturbing the divide.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (nd) begin
`ifdef RADIX2_DIV_EARLY_OUT_EN
                    w_nextState = w_early ? DONE : CALC;
`else
                    w_nextState = CALC;
`endif
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Operand capture, the shift/subtract iteration and result registering.
    // valid is a single-cycle pulse because DONE always hands straight back
    // to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_signQ <= 1'b0;
            r_signR <= 1'b0;
            r_zero  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (nd) begin
                        r_div   <= w_absB;
                        r_quo   <= w_absA;
                        r_rem   <= '0;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_signQ <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_signR <= a[WIDTH-1];
                        r_zero  <= w_bZero;
`ifdef RADIX2_DIV_EARLY_OUT_EN
                        if (w_early) begin
                            r_quo <= '0;
                            r_rem <= w_absA;
                        end
`endif
                    end
                end
                CALC: begin
                    if (w_fits) begin
                        r_rem <= w_diff[WIDTH-1:0];
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                    end
                    r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt - CW'(1);
                end
                DONE: begin
                    r_q     <= w_qOut;
                    r_r     <= w_rOut;
                    r_dbz   <= r_zero;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign q           = r_q;
    assign r           = r_r;
    assign valid       = r_valid;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_radix2_div.sv
// ---------------------------------------------------------------------------
// tb_radix2_div
//
// Self-checking bench for radix2_div at WIDTH=32.  Each accepted operation
// pushes its expected quotient, remainder, divide-by-zero flag and latency
// onto a scoreboard queue; a monitor pops and compares on every valid pulse.
// Scenario tasks add their own checks for reset values, busy behaviour,
// aborted operations and queue drain.
// ---------------------------------------------------------------------------
module tb_radix2_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         nd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         valid;
    logic         busy;
    logic         div_by_zero;

    int checks     = 0;
    int errors     = 0;
    int edgeCount  = 0;
    int validCount = 0;
    logic prevValid = 1'b0;

    typedef struct {
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        logic [W-1:0] expQ;
        logic [W-1:0] expR;
        logic         expDbz;
        int           issueEdge;
        int           expLat;
    } exp_t;

    exp_t sb[$];
    exp_t monExp;

    radix2_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .nd          (nd),
        .a           (a),
        .b           (b),
        .q           (q),
        .r           (r),
        .valid       (valid),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock and edge counter used to time latency.
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Scoreboard consumer: every valid pulse must match the oldest
    // outstanding expectation, arrive after the expected number of edges,
    // and never follow another valid directly.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            validCount++;
            checks++;
            if (prevValid === 1'b1) begin
                errors++;
                $display("[TB] FAIL valid_pulse: valid high two cycles in a row at edge %0d", edgeCount);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_valid: got q=%0d r=%0d with nothing outstanding", $signed(q), $signed(r));
            end else begin
                monExp = sb.pop_front();
                checks++;
                if (q !== monExp.expQ) begin
                    errors++;
                    $display("[TB] FAIL quotient %0d/%0d: got %0d want %0d", $signed(monExp.ta), $signed(monExp.tb), $signed(q), $signed(monExp.expQ));
                end
                checks++;
                if (r !== monExp.expR) begin
                    errors++;
                    $display("[TB] FAIL remainder %0d/%0d: got %0d want %0d", $signed(monExp.ta), $signed(monExp.tb), $signed(r), $signed(monExp.expR));
                end
                checks++;
                if (div_by_zero !== monExp.expDbz) begin
                    errors++;
                    $display("[TB] FAIL div_by_zero %0d/%0d: got %b want %b", $signed(monExp.ta), $signed(monExp.tb), div_by_zero, monExp.expDbz);
                end
                checks++;
                if ((edgeCount - monExp.issueEdge) != monExp.expLat) begin
                    errors++;
                    $display("[TB] FAIL latency %0d/%0d: got %0d edges want %0d", $signed(monExp.ta), $signed(monExp.tb), edgeCount - monExp.issueEdge, monExp.expLat);
                end
            end
        end
        prevValid = valid;
    end

    // Drive one nd strobe starting at the current negedge; when the divider
    // is expected to take it, record the reference result on the scoreboard.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit expectAccept);
        exp_t   e;
        longint la;
        longint lb;
        longint lq;
        longint lr;
        longint absA;
        longint absB;
        a  = ta;
        b  = tb;
        nd = 1'b1;
        if (expectAccept) begin
            la = longint'($signed(ta));
            lb = longint'($signed(tb));
            e.ta = ta;
            e.tb = tb;
            if (lb == 0) begin
                e.expQ   = '1;
                e.expR   = ta;
                e.expDbz = 1'b1;
            end else begin
                lq = la / lb;
                lr = la % lb;
                e.expQ   = lq[W-1:0];
                e.expR   = lr[W-1:0];
                e.expDbz = 1'b0;
            end
            absA = (la < 0) ? -la : la;
            absB = (lb < 0) ? -lb : lb;
`ifdef RADIX2_DIV_EARLY_OUT_EN
            e.expLat = ((lb == 0) || (absA < absB)) ? 1 : W + 1;
`else
            e.expLat = (absA >= 0 && absB >= 0) ? W + 1 : W + 1;
`endif
            e.issueEdge = edgeCount + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        nd = 1'b0;
    endtask

    // Wait (bounded) until every outstanding operation has reported.
    task automatic waitIdle(input int maxCycles);
        for (int i = 0; i < maxCycles && (sb.size() != 0 || busy === 1'b1); i++) begin
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        nd      = 1'b0;
        a       = '0;
        b       = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (q !== '0) begin errors++; $display("[TB] FAIL reset_q: got %h want 0", q); end
        checks++;
        if (r !== '0) begin errors++; $display("[TB] FAIL reset_r: got %h want 0", r); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b want 0", div_by_zero); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal();
        logic [W-1:0] va [8] = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'd3, 32'd0, 32'd7, -32'sd7};
        logic [W-1:0] vb [8] = '{32'd7, 32'd7, -32'sd7, -32'sd7, 32'd7, 32'd5, 32'd7, 32'd2};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(va[i], vb[i], 1'b1);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_nd: got %b want 1", busy); end
            waitIdle(80);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL normal_drain: got %0d outstanding want 0", sb.size()); end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] va [6] = '{32'h8000_0000, 32'h8000_0000, 32'd5, -32'sd5, 32'h7fff_ffff, 32'h8000_0000};
        logic [W-1:0] vb [6] = '{32'hffff_ffff, 32'd1, 32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(va[i], vb[i], 1'b1);
            waitIdle(80);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL boundary_drain: got %0d outstanding want 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int  vc;
        bit  seen;
        applyStimulus(32'd1000, 32'd10, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid_op: got %b want 1", busy); end
        applyStimulus(32'd9, 32'd3, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL busy_first_valid: got no valid want one within 80 cycles"); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_in_valid_cycle: got %b want 0", busy); end
        applyStimulus(32'd9, 32'd3, 1'b1);
        waitIdle(80);
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL back_to_back_drain: got %0d outstanding want 0", sb.size()); end
        vc = validCount;
        repeat (40) @(negedge clk);
        checks++;
        if (validCount != vc) begin errors++; $display("[TB] FAIL ignored_nd_valid: got %0d extra valids want 0", validCount - vc); end
    endtask

    task automatic test_reset_midop();
        int vc;
        applyStimulus(32'd50, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        vc = validCount;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (q !== '0) begin errors++; $display("[TB] FAIL midop_reset_q: got %h want 0", q); end
        checks++;
        if (r !== '0) begin errors++; $display("[TB] FAIL midop_reset_r: got %h want 0", r); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midop_reset_busy: got %b want 0", busy); end
        repeat (40) @(negedge clk);
        checks++;
        if (validCount != vc) begin errors++; $display("[TB] FAIL midop_no_valid: got %0d valids want 0", validCount - vc); end
    endtask

    task automatic test_random();
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        for (int i = 0; i < 1000; i++) begin
            ta = $urandom >> $urandom_range(0, 31);
            tb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ta = -ta;
            if ($urandom_range(0, 1) == 1) tb = -tb;
            if (tb == '0) tb = 32'd1;
            applyStimulus(ta, tb, 1'b1);
            waitIdle(80);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL random_drain: got %0d outstanding want 0", sb.size()); end
    endtask

    initial begin
        nd      = 1'b0;
        a       = '0;
        b       = '0;
        reset_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_normal();
        test_boundaries();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the design wedges somewhere no bounded wait covers.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d outstanding", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
